// File: rtl/master_sync_fwft_fifo.sv
// Single-clock parametrised FIFO with standard or first-word-fall-through read,
// registered level/threshold flags, sticky overflow/underflow and synchronous flush.
module master_sync_fwft_fifo #(
    parameter int DATA_WIDTH       = 19,
    parameter int DEPTH_WIDTH      = 9,
    parameter int FWFT             = 0,
    parameter int ALMOST_FULL_NUM  = 20,
    parameter int ALMOST_EMPTY_NUM = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_full,
    output logic                  almost_full,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_empty,
    output logic                  almost_empty,
    output logic [DEPTH_WIDTH:0]  water_level,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH   = 1 << DEPTH_WIDTH;
    localparam int LW      = DEPTH_WIDTH + 1;
    localparam bit IS_FWFT = (FWFT != 0);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [LW-1:0]         wr_ptr;
    logic [LW-1:0]         rd_ptr;
    logic [LW-1:0]         level_next;
    logic                  out_valid;
    logic                  out_valid_next;
    logic                  wr_acc;
    logic                  rd_acc;
    logic                  arr_nonempty;
    logic                  load;

    // load moves the array head into rd_data: on an accepted read in standard
    // mode, or whenever the FWFT output stage is free or being popped.
    always_comb begin
        wr_acc         = wr_en & ~wr_full;
        rd_acc         = rd_en & ~rd_empty;
        arr_nonempty   = (wr_ptr != rd_ptr);
        load           = rd_acc;
        out_valid_next = 1'b0;
        if (IS_FWFT) begin
            load           = arr_nonempty & (~out_valid | rd_acc);
            out_valid_next = load | (out_valid & ~rd_acc);
        end
        level_next = water_level;
        case ({wr_acc, rd_acc})
            2'b10:   level_next = water_level + LW'(1);
            2'b01:   level_next = water_level - LW'(1);
            default: level_next = water_level;
        endcase
    end

    // NOTE: storage has no reset; contents are don't-care after reset or flush
    // because the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (wr_acc && !flush) begin
            mem[wr_ptr[DEPTH_WIDTH-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            out_valid    <= 1'b0;
            rd_data      <= '0;
            water_level  <= '0;
            wr_full      <= 1'b0;
            almost_full  <= 1'b0;
            rd_empty     <= 1'b1;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else if (flush) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            out_valid    <= 1'b0;
            rd_data      <= '0;
            water_level  <= '0;
            wr_full      <= 1'b0;
            almost_full  <= 1'b0;
            rd_empty     <= 1'b1;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + LW'(1);
            end
            if (load) begin
                rd_ptr  <= rd_ptr + LW'(1);
                rd_data <= mem[rd_ptr[DEPTH_WIDTH-1:0]];
            end
            out_valid   <= out_valid_next;
            water_level <= level_next;
            // NOTE: flags are derived from the next level so they change on the
            // same edge as water_level instead of trailing it by a cycle.
            wr_full      <= (level_next == LW'(DEPTH));
            almost_full  <= (level_next >= LW'(ALMOST_FULL_NUM));
            almost_empty <= (level_next <= LW'(ALMOST_EMPTY_NUM));
            rd_empty     <= IS_FWFT ? ~out_valid_next : (level_next == '0);
            if (wr_en && wr_full) begin
                overflow <= 1'b1;
            end
            if (rd_en && rd_empty) begin
                underflow <= 1'b1;
            end
        end
    end

endmodule
